// File: rtl/smc_serial.sv
// smc_serial: serial six-device SMC ranking responder.
// Each in_valid beat carries one (W, V_GS, V_DS) triple. The per-beat I_D or g_m
// value is stored. After six beats the values are sorted in descending order over
// three cycles, two phases per cycle. One weighted top-3 or bottom-3 result is then
// returned with a single-cycle out_valid pulse.
//
// Handshake: in_valid qualifies mode/W/V_GS/V_DS on a rising edge. Beats are
// accepted only in IDLE (when no result pulse is showing) and in LOAD. Beats that
// arrive during SORT, during OUT or during the result pulse are dropped. out_valid
// is high for exactly one cycle. out_n is zero whenever out_valid is low.
module smc_serial #(
  parameter int DEV_NUM = 6,
  parameter int IN_W    = 3,
  parameter int OUT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  W,
  input  logic [IN_W-1:0]  V_GS,
  input  logic [IN_W-1:0]  V_DS,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n,
  output logic [1:0]       dbg_state
);

  localparam int VAL_W = 7;
  localparam int CALC_W = 12;
  localparam logic [2:0] LAST_BEAT = 3'(DEV_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SORT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_beat_cnt;
  logic [1:0]         r_sort_cnt;
  logic [1:0]         r_mode;
  logic [VAL_W-1:0]   r_val [DEV_NUM];
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_n;

  logic               w_load_en;
  logic [2:0]         w_load_idx;
  logic               w_sort_en;
  logic               w_out_en;

  // Per-beat device model signals
  logic [CALC_W-1:0]  w_w;
  logic [CALC_W-1:0]  w_vgs;
  logic [CALC_W-1:0]  w_vds;
  logic [CALC_W-1:0]  w_vov;
  logic [CALC_W-1:0]  w_tri_term;
  logic [CALC_W-1:0]  w_id;
  logic [CALC_W-1:0]  w_gm;
  logic               w_triode;
  logic               w_sel_id;
  logic [VAL_W-1:0]   w_beat_val;

  // Sort network and result signals
  logic [VAL_W-1:0]   w_ph1 [DEV_NUM];
  logic [VAL_W-1:0]   w_ph2 [DEV_NUM];
  logic [OUT_W-1:0]   w_a;
  logic [OUT_W-1:0]   w_b;
  logic [OUT_W-1:0]   w_c;
  logic [OUT_W-1:0]   w_result;

  // Device model for the beat on the inputs. Wide unsigned arithmetic keeps
  // illegal zero operands from disturbing anything beyond the stored value.
  always_comb begin
    w_w        = CALC_W'(W);
    w_vgs      = CALC_W'(V_GS);
    w_vds      = CALC_W'(V_DS);
    w_vov      = w_vgs - CALC_W'(1);
    w_triode   = w_vgs > (w_vds + CALC_W'(1));
    w_tri_term = (CALC_W'(2) * w_vgs) - CALC_W'(2) - w_vds;
    if (w_triode) begin
      w_id = (w_w * w_vds * w_tri_term) / CALC_W'(3);
      w_gm = (CALC_W'(2) * w_w * w_vds) / CALC_W'(3);
    end else begin
      w_id = (w_w * w_vov * w_vov) / CALC_W'(3);
      w_gm = (CALC_W'(2) * w_w * w_vov) / CALC_W'(3);
    end
    // On the first beat mode is still on the inputs. Later beats use the latched copy.
    w_sel_id   = (r_state == S_IDLE) ? mode[0] : r_mode[0];
    w_beat_val = w_sel_id ? VAL_W'(w_id) : VAL_W'(w_gm);
  end

  // One sort cycle: even-pair phase, then odd-pair phase, both descending.
  always_comb begin
    for (int i = 0; i < DEV_NUM; i++) begin
      w_ph1[i] = r_val[i];
    end
    for (int i = 0; i + 1 < DEV_NUM; i += 2) begin
      if (r_val[i] < r_val[i+1]) begin
        w_ph1[i]   = r_val[i+1];
        w_ph1[i+1] = r_val[i];
      end
    end
    for (int i = 0; i < DEV_NUM; i++) begin
      w_ph2[i] = w_ph1[i];
    end
    for (int i = 1; i + 1 < DEV_NUM; i += 2) begin
      if (w_ph1[i] < w_ph1[i+1]) begin
        w_ph2[i]   = w_ph1[i+1];
        w_ph2[i+1] = w_ph1[i];
      end
    end
  end

  // Result from sorted values. mode[1] picks top or bottom three. mode[0] (I_D)
  // selects the 3/4/5 weighting; g_m uses a plain sum.
  always_comb begin
    if (r_mode[1]) begin
      w_a = OUT_W'(r_val[0]);
      w_b = OUT_W'(r_val[1]);
      w_c = OUT_W'(r_val[2]);
    end else begin
      w_a = OUT_W'(r_val[3]);
      w_b = OUT_W'(r_val[4]);
      w_c = OUT_W'(r_val[5]);
    end
    if (r_mode[0]) begin
      w_result = (OUT_W'(3) * w_a) + (OUT_W'(4) * w_b) + (OUT_W'(5) * w_c);
    end else begin
      w_result = w_a + w_b + w_c;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load_en   = 1'b0;
    w_load_idx  = r_beat_cnt;
    w_sort_en   = 1'b0;
    w_out_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid && !r_out_valid) begin
          w_load_en   = 1'b1;
          w_load_idx  = 3'd0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_load_en = 1'b1;
          if (r_beat_cnt == LAST_BEAT) begin
            w_state_nxt = S_SORT;
          end
        end
      end
      S_SORT: begin
        w_sort_en = 1'b1;
        if (r_sort_cnt == 2'd2) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        w_out_en    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beat capture, sort steps and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= 3'd0;
      r_sort_cnt <= 2'd0;
      r_mode     <= 2'd0;
      for (int i = 0; i < DEV_NUM; i++) begin
        r_val[i] <= '0;
      end
    end else begin
      if (w_load_en) begin
        r_val[w_load_idx] <= w_beat_val;
        if (w_load_idx == 3'd0) begin
          r_mode <= mode;
        end
        r_beat_cnt <= (w_load_idx == LAST_BEAT) ? 3'd0 : (w_load_idx + 3'd1);
      end
      if (w_sort_en) begin
        for (int i = 0; i < DEV_NUM; i++) begin
          r_val[i] <= w_ph2[i];
        end
        r_sort_cnt <= r_sort_cnt + 2'd1;
      end
      if (w_out_en) begin
        r_sort_cnt <= 2'd0;
      end
    end
  end

  // Registered result pulse. out_n is forced to zero outside the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_n     <= '0;
    end else if (w_out_en) begin
      r_out_valid <= 1'b1;
      r_out_n     <= w_result;
    end else begin
      r_out_valid <= 1'b0;
      r_out_n     <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_n     = r_out_n;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_smc_serial.sv
// tb_smc_serial: random and directed transactions for smc_serial. Expected results
// come from a behavioural model of the device equations and ranking rules.
module tb_smc_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] mode;
  logic [2:0] W;
  logic [2:0] V_GS;
  logic [2:0] V_DS;
  logic       out_valid;
  logic [9:0] out_n;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulses  = 0;

  logic [9:0] exp_q[$];
  int         lat_q[$];

  int b_w[6];
  int b_vgs[6];
  int b_vds[6];

  smc_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .W(W), .V_GS(V_GS), .V_DS(V_DS),
    .out_valid(out_valid), .out_n(out_n), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int dev_val(int use_id, int w, int vgs, int vds);
    int id, gm;
    if (vgs - 1 > vds) begin
      id = w * vds * (2 * vgs - 2 - vds) / 3;
      gm = 2 * w * vds / 3;
    end else begin
      id = w * (vgs - 1) * (vgs - 1) / 3;
      gm = 2 * w * (vgs - 1) / 3;
    end
    return use_id ? id : gm;
  endfunction

  function automatic logic [9:0] model(int md);
    int s[6];
    int t, res;
    for (int i = 0; i < 6; i++) s[i] = dev_val(md & 1, b_w[i], b_vgs[i], b_vds[i]);
    for (int i = 1; i < 6; i++) begin
      for (int j = i; j > 0 && s[j] > s[j-1]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    end
    case (md)
      3: res = 3 * s[0] + 4 * s[1] + 5 * s[2];
      1: res = 3 * s[3] + 4 * s[4] + 5 * s[5];
      2: res = s[0] + s[1] + s[2];
      default: res = s[3] + s[4] + s[5];
    endcase
    return 10'(res);
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // exp_val < 0 means "use the model". want_out = 0 drives beats without expecting a result.
  task automatic run_txn(int md, int gap3, bit rgap, bit hold, int exp_val, bit want_out);
    int p0;
    if (want_out) exp_q.push_back((exp_val >= 0) ? 10'(exp_val) : model(md));
    for (int b = 0; b < 6; b++) begin
      int g;
      g = (b == 3) ? gap3 : 0;
      if (rgap && b > 0) g += $urandom_range(0, 1);
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        W = 3'($urandom); V_GS = 3'($urandom); V_DS = 3'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      mode = (b == 0) ? 2'(md) : 2'($urandom);
      W = 3'(b_w[b]); V_GS = 3'(b_vgs[b]); V_DS = 3'(b_vds[b]);
    end
    @(posedge clk);
    #1;
    if (want_out) lat_q.push_back(cyc);
    if (hold) begin
      W = 3'd7; V_GS = 3'd7; V_DS = 3'($urandom_range(1, 7));
    end else begin
      in_valid = 1'b0;
    end
    if (!want_out) return;
    p0 = pulses;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (pulses != p0) break;
    end
    in_valid = 1'b0;
    check("pulse_seen", int'(pulses != p0), 1);
    if (hold) begin
      repeat (12) @(negedge clk);
      check("single_pulse", pulses - p0, 1);
    end
  endtask

  task automatic set_beats_uniform(int w, int vgs, int vds);
    for (int i = 0; i < 6; i++) begin
      b_w[i] = w; b_vgs[i] = vgs; b_vds[i] = vds;
    end
  endtask

  task automatic set_beats_ramp();
    for (int i = 0; i < 6; i++) begin
      b_w[i] = i + 1; b_vgs[i] = 4; b_vds[i] = 7;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          check("out_n", int'(out_n), int'(exp_q.pop_front()));
          check("latency", cyc - lat_q.pop_front(), 4);
        end
      end else begin
        check("idle_zero", int'(out_n), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    rst = 1'b1; in_valid = 1'b0; mode = 2'd0; W = 3'd0; V_GS = 3'd0; V_DS = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_n", int'(out_n), 0);
    check("rst_state", int'(dbg_state), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: triode, ID=1 / gm=0
    set_beats_uniform(1, 3, 1);
    run_txn(1, 0, 0, 0, 12, 1);
    run_txn(0, 0, 0, 0, 0, 1);
    // Directed: saturation maximum
    set_beats_uniform(7, 7, 7);
    run_txn(3, 0, 0, 0, 1008, 1);
    run_txn(2, 0, 0, 0, 84, 1);
    // Directed: ramp of W, all four modes
    set_beats_ramp();
    run_txn(3, 0, 0, 0, 174, 1);
    run_txn(1, 0, 0, 0, 66, 1);
    run_txn(2, 0, 0, 0, 30, 1);
    run_txn(0, 0, 0, 0, 12, 1);
    // Gap of two idle cycles between beats 3 and 4
    run_txn(3, 2, 0, 0, 174, 1);

    // Reset while sorting: no pulse, back to IDLE, then a clean transaction
    run_txn(3, 0, 0, 0, -1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midsort_rst_valid", int'(out_valid), 0);
    check("midsort_rst_n", int'(out_n), 0);
    check("midsort_rst_state", int'(dbg_state), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (10) @(negedge clk);
    check("no_pulse_after_rst", pulses - p0, 0);
    set_beats_uniform(7, 7, 7);
    run_txn(3, 0, 0, 0, 1008, 1);

    // in_valid held high through SORT/OUT
    for (int i = 0; i < 6; i++) begin
      b_w[i] = 7; b_vgs[i] = 7; b_vds[i] = $urandom_range(1, 7);
    end
    run_txn($urandom_range(0, 3), 0, 0, 1, -1, 1);

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 6; i++) begin
        b_w[i] = $urandom_range(1, 7);
        b_vgs[i] = $urandom_range(1, 7);
        b_vds[i] = $urandom_range(1, 7);
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1, ($urandom_range(0, 4) == 0), -1, 1);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
